// File: rtl/nn_pkg.sv
// Shared types, config address map and activation helper for the MAC sequencer.
// Latency: none (types and a combinational function only).
// Backpressure: not applicable.
package nn_pkg;

   typedef enum logic [1:0] {IDLE, MAC, ACT, DONE} state_t;

   // Accumulator commands issued by the sequencer each cycle
   typedef enum logic [1:0] {OP_HOLD, OP_START, OP_CLR, OP_ADD} mac_op_t;

   localparam logic [3:0] ADDR_W1    = 4'd0;
   localparam logic [3:0] ADDR_W2    = 4'd1;
   localparam logic [3:0] ADDR_W3    = 4'd2;
   localparam logic [3:0] ADDR_W4    = 4'd3;
   localparam logic [3:0] ADDR_W5    = 4'd4;
   localparam logic [3:0] ADDR_W6    = 4'd5;
   localparam logic [3:0] ADDR_BIAS1 = 4'd6;
   localparam logic [3:0] ADDR_BIAS2 = 4'd7;
   localparam logic [3:0] ADDR_BIAS3 = 4'd8;

   // ReLU followed by clipping to the largest positive out_w-bit signed value
   function automatic logic signed [31:0] relu_clip(input logic signed [31:0] r, input int out_w);
      logic signed [31:0] top_val;
      top_val = (32'sd1 <<< (out_w - 1)) - 32'sd1;
      if (r < 0)
         return 32'sd0;
      else if (r > top_val)
         return top_val;
      else
         return r;
   endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Shared signed multiply-accumulate with floor-shift/ReLU-clip activation; NN_SAT_EN selects saturating accumulate.
// Latency: one cycle per accumulate; activation output is combinational from the accumulator.
// Backpressure: none, the sequencer issues one command per cycle.
module nn_mac_unit
   import nn_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int WT_W  = 8,
   parameter int FRAC  = 7,
   parameter int ACC_W = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  mac_op_t                op,
   input  logic                   use_bias,
   input  logic signed [IN_W-1:0] a,
   input  logic signed [WT_W-1:0] w,
   input  logic signed [IN_W-1:0] bias,
   output logic signed [IN_W-1:0] act,
   output logic                   ovf
);

   logic signed [IN_W+WT_W-1:0] prod;
   logic signed [ACC_W-1:0]     term;
   logic signed [ACC_W-1:0]     acc;
   logic signed [ACC_W-1:0]     acc_next;
   logic signed [ACC_W-1:0]     shifted;
   logic                        ovf_evt;

   assign prod = (IN_W+WT_W)'(a) * (IN_W+WT_W)'(w);
   // Bias is integer-valued, so it is moved onto the product's fixed-point grid
   assign term = use_bias ? (ACC_W'(bias) <<< FRAC) : ACC_W'(prod);

`ifdef NN_SAT_EN
   logic signed [ACC_W:0] sum;
   assign sum = (ACC_W+1)'(acc) + (ACC_W+1)'(term);

   // Clamp to the accumulator range when the extra sign bit disagrees
   always_comb begin
      acc_next = sum[ACC_W-1:0];
      ovf_evt  = 1'b0;
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         ovf_evt  = 1'b1;
         acc_next = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
   end
`else
   assign acc_next = acc + term;
   assign ovf_evt  = 1'b0;
`endif

   // Accumulator and per-evaluation sticky overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
         ovf <= 1'b0;
      end else begin
         case (op)
            OP_START: begin
               acc <= '0;
               ovf <= 1'b0;
            end
            OP_CLR: acc <= '0;
            OP_ADD: begin
               acc <= acc_next;
               ovf <= ovf | ovf_evt;
            end
            default: ;
         endcase
      end
   end

   assign shifted = acc >>> FRAC;
   assign act     = IN_W'(relu_clip(32'(shifted), IN_W));

endmodule

// File: rtl/nn_mac_sequencer.sv
// Evaluates the 2-2-1 network h1 -> h2 -> o1 on one shared MAC; NN_SAT_EN enables saturating accumulate.
// Latency: start accepted at E0, h1/h2/out_o1 written at E4/E8/E12, done high in the cycle after E12.
// Backpressure: start ignored while not IDLE; config writes while busy or in DONE are dropped with cfg_err.
module nn_mac_sequencer
   import nn_pkg::*;
#(
   parameter int IN_W  = 8,
   parameter int WT_W  = 8,
   parameter int FRAC  = 7,
   parameter int ACC_W = 20
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   cfg_we,
   input  logic [3:0]             cfg_addr,
   input  logic [WT_W-1:0]        cfg_wdata,
   output logic                   cfg_err,
   input  logic                   start,
   input  logic signed [IN_W-1:0] in1,
   input  logic signed [IN_W-1:0] in2,
   output logic                   busy,
   output logic                   done,
   output logic signed [IN_W-1:0] h1_out,
   output logic signed [IN_W-1:0] h2_out,
   output logic signed [IN_W-1:0] out_o1,
   output logic                   ovf
);

   state_t                 state, next_state;
   mac_op_t                op;
   logic [1:0]             n, k;
   logic signed [WT_W-1:0] w [6];
   logic signed [IN_W-1:0] bias [3];
   logic signed [IN_W-1:0] in1_lat, in2_lat;
   logic signed [IN_W-1:0] src_a, src_b, mac_a, mac_bias, act;
   logic signed [WT_W-1:0] mac_w;
   logic                   use_bias;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next state and accumulator command
   always_comb begin
      next_state = state;
      op         = OP_HOLD;
      case (state)
         IDLE: if (start) begin
            next_state = MAC;
            op         = OP_START;
         end
         MAC: begin
            op = OP_ADD;
            if (k == 2'd2) next_state = ACT;
         end
         ACT: begin
            op         = OP_CLR;
            next_state = (n == 2'd2) ? DONE : MAC;
         end
         default: next_state = IDLE;
      endcase
   end

   // Output neuron reuses the hidden results as its inputs
   assign src_a    = (n == 2'd2) ? h1_out : in1_lat;
   assign src_b    = (n == 2'd2) ? h2_out : in2_lat;
   assign mac_a    = (k == 2'd0) ? src_a : src_b;
   assign mac_w    = w[{n, k[0]}];
   assign mac_bias = bias[n];
   assign use_bias = (k == 2'd2);

   assign busy = (state == MAC) || (state == ACT);
   assign done = (state == DONE);

   // Term/neuron counters, input latches and activated results
   always_ff @(posedge clk) begin
      if (rst) begin
         n       <= '0;
         k       <= '0;
         in1_lat <= '0;
         in2_lat <= '0;
         h1_out  <= '0;
         h2_out  <= '0;
         out_o1  <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               in1_lat <= in1;
               in2_lat <= in2;
               n       <= '0;
               k       <= '0;
            end
            MAC: k <= k + 2'd1;
            ACT: begin
               case (n)
                  2'd0:    h1_out <= act;
                  2'd1:    h2_out <= act;
                  default: out_o1 <= act;
               endcase
               k <= '0;
               n <= n + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // Config register file; writes only land while idle so an evaluation sees stable parameters
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 6; i++) w[i] <= '0;
         for (int i = 0; i < 3; i++) bias[i] <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= cfg_we && (state != IDLE);
         if (cfg_we && (state == IDLE)) begin
            for (int i = 0; i < 6; i++)
               if (cfg_addr == ADDR_W1 + 4'(i)) w[i] <= cfg_wdata;
            for (int i = 0; i < 3; i++)
               if (cfg_addr == ADDR_BIAS1 + 4'(i)) bias[i] <= cfg_wdata[IN_W-1:0];
         end
      end
   end

   nn_mac_unit #(
      .IN_W (IN_W),
      .WT_W (WT_W),
      .FRAC (FRAC),
      .ACC_W(ACC_W)
   ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .op      (op),
      .use_bias(use_bias),
      .a       (mac_a),
      .w       (mac_w),
      .bias    (mac_bias),
      .act     (act),
      .ovf     (ovf)
   );

endmodule

// File: tb/tb_nn_mac_sequencer.sv
// Bench for nn_mac_sequencer: 20-bit and 16-bit accumulator instances against an arithmetic network model.
// Latency: expects done 12 edges after the accepting edge.
// Backpressure: exercises ignored starts and rejected config writes.
module tb_nn_mac_sequencer;

`ifdef NN_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [7:0] h1;
      logic [7:0] h2;
      logic [7:0] o1;
      logic       ovf;
      logic [7:0] lat;
   } res_t;

   logic              clk = 1'b0;
   logic              rst, cfg_we, start;
   logic [3:0]        cfg_addr;
   logic [7:0]        cfg_wdata;
   logic signed [7:0] in1, in2;
   logic              cfg_err20, busy20, done20, ovf20;
   logic [7:0]        h1_20, h2_20, o1_20;
   logic              cfg_err16, busy16, done16, ovf16;
   logic [7:0]        h1_16, h2_16, o1_16;

   int   errs = 0;
   int   checks = 0;
   int   mw [6];
   int   mb [3];
   res_t got20, got16, exp;
   int   ndone, nerr;
   logic busy0, rst_busy;
   logic [7:0] rst_or;

   always #5 clk = ~clk;

   nn_mac_sequencer #(.IN_W(8), .WT_W(8), .FRAC(7), .ACC_W(20)) dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_err(cfg_err20), .start(start), .in1(in1), .in2(in2), .busy(busy20), .done(done20),
      .h1_out(h1_20), .h2_out(h2_20), .out_o1(o1_20), .ovf(ovf20));

   nn_mac_sequencer #(.IN_W(8), .WT_W(8), .FRAC(7), .ACC_W(16)) dut16 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
      .cfg_err(cfg_err16), .start(start), .in1(in1), .in2(in2), .busy(busy16), .done(done16),
      .h1_out(h1_16), .h2_out(h2_16), .out_o1(o1_16), .ovf(ovf16));

   // One neuron: three accumulate steps, floor division by 128, ReLU, clip. Bit 8 of result = overflow.
   function automatic int neuron(int a, int wa, int b, int wb, int bias, int aw);
      longint terms [3];
      longint acc, s, half, r;
      bit     o;
      acc = 0;
      o   = 1'b0;
      terms[0] = longint'(a) * wa;
      terms[1] = longint'(b) * wb;
      terms[2] = longint'(bias) * 128;
      half = longint'(1) << (aw - 1);
      for (int i = 0; i < 3; i++) begin
         s = acc + terms[i];
         if (SAT) begin
            if (s > half - 1) begin s = half - 1; o = 1'b1; end
            else if (s < -half) begin s = -half; o = 1'b1; end
         end else begin
            s = s & (2 * half - 1);
            if (s >= half) s = s - 2 * half;
         end
         acc = s;
      end
      r = (acc >= 0) ? acc / 128 : -((-acc + 127) / 128);
      if (r < 0) r = 0;
      else if (r > 127) r = 127;
      return int'(r) + (o ? 256 : 0);
   endfunction

   function automatic res_t model(int a, int b, int aw);
      int   h1, h2, o1;
      res_t r;
      h1 = neuron(a, mw[0], b, mw[1], mb[0], aw);
      h2 = neuron(a, mw[2], b, mw[3], mb[1], aw);
      o1 = neuron(h1 % 256, mw[4], h2 % 256, mw[5], mb[2], aw);
      r.h1  = h1[7:0];
      r.h2  = h2[7:0];
      r.o1  = o1[7:0];
      r.ovf = (h1 >= 256) || (h2 >= 256) || (o1 >= 256);
      r.lat = 8'd12;
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wcfg(input int addr, input int val);
      logic signed [7:0] v8;
      v8 = val[7:0];
      cfg_we    = 1'b1;
      cfg_addr  = addr[3:0];
      cfg_wdata = val[7:0];
      tick();
      cfg_we = 1'b0;
      if (addr < 6) mw[addr] = v8;
      else if (addr < 9) mb[addr - 6] = v8;
   endtask

   // mode 0 plain, 1 write+starts while busy, 2 reset at E6, 3 write during DONE, 4 bias1 write with start
   task automatic run(input int a, input int b, input int mode);
      in1 = a[7:0];
      in2 = b[7:0];
      start = 1'b1;
      if (mode == 4) begin
         cfg_we = 1'b1; cfg_addr = 4'd6; cfg_wdata = 8'd10;
      end
      tick();
      start = 1'b0;
      cfg_we = 1'b0;
      busy0 = busy20 & busy16;
      got20 = '0; got16 = '0; ndone = 0; nerr = 0;
      rst_busy = 1'b0; rst_or = '0;
      for (int e = 1; e <= 16; e++) begin
         cfg_we = 1'b0; start = 1'b0; rst = 1'b0;
         if (mode == 1) begin
            if (e == 2) begin cfg_we = 1'b1; cfg_addr = 4'd0; cfg_wdata = 8'd5; end
            if (e == 3 || e == 7 || e == 11 || e == 12) start = 1'b1;
         end
         if (mode == 3 && e == 13) begin cfg_we = 1'b1; cfg_addr = 4'd1; cfg_wdata = 8'd9; end
         if (mode == 2 && e == 6) rst = 1'b1;
         tick();
         if (cfg_err20) nerr++;
         if (done20) begin
            ndone++;
            if (got20.lat == 0) got20 = {h1_20, h2_20, o1_20, ovf20, 8'(e)};
         end
         if (done16 && got16.lat == 0) got16 = {h1_16, h2_16, o1_16, ovf16, 8'(e)};
         if (mode == 2 && e == 6) begin
            rst_busy = busy20 | busy16;
            rst_or   = h1_20 | h2_20 | o1_20 | h1_16 | h2_16 | o1_16;
         end
      end
      cfg_we = 1'b0; start = 1'b0; rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_we = 1'b0; start = 1'b0; cfg_addr = '0; cfg_wdata = '0; in1 = '0; in2 = '0;
      tick();
      tick();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) mw[i] = 0;
      for (int i = 0; i < 3; i++) mb[i] = 0;
      checks++;
      if ({busy20, done20, cfg_err20, ovf20, h1_20, h2_20, o1_20} !== '0) begin
         errs++; $display("FAIL reset20 got=%h required=0", {busy20, done20, cfg_err20, ovf20, h1_20, h2_20, o1_20});
      end
      checks++;
      if ({busy16, done16, cfg_err16, ovf16, h1_16, h2_16, o1_16} !== '0) begin
         errs++; $display("FAIL reset16 got=%h required=0", {busy16, done16, cfg_err16, ovf16, h1_16, h2_16, o1_16});
      end
   endtask

   task automatic test_basic();
      for (int i = 0; i < 6; i++) wcfg(i, 64);
      for (int i = 6; i < 9; i++) wcfg(i, 0);
      run(2, 3, 0);
      exp = {8'd2, 8'd2, 8'd2, 1'b0, 8'd12};
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL basic20 got=%h required=%h", got20, exp); end
      exp = model(2, 3, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL basic16 got=%h required=%h", got16, exp); end
      checks++;
      if (busy0 !== 1'b1) begin errs++; $display("FAIL busy_e0 got=%b required=1", busy0); end
      checks++;
      if (ndone != 1) begin errs++; $display("FAIL basic_done_count got=%0d required=1", ndone); end
   endtask

   task automatic test_relu();
      wcfg(0, -128); wcfg(1, 0); wcfg(6, 0);
      wcfg(2, 64); wcfg(3, 64); wcfg(7, 1);
      run(3, 4, 0);
      exp = {8'd0, 8'd4, 8'd2, 1'b0, 8'd12};
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL relu20 got=%h required=%h", got20, exp); end
      exp = model(3, 4, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL relu16 got=%h required=%h", got16, exp); end
   endtask

   task automatic test_clip();
      for (int i = 0; i < 9; i++) wcfg(i, 127);
      run(127, 127, 0);
      exp = {8'd127, 8'd127, 8'd127, 1'b0, 8'd12};
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL clip20 got=%h required=%h", got20, exp); end
      exp = model(127, 127, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL clip16 got=%h required=%h", got16, exp); end
   endtask

   task automatic test_random();
      int a, b;
      for (int it = 0; it < 10; it++) begin
         for (int i = 0; i < 9; i++) wcfg(i, int'($urandom_range(0, 255)) - 128);
         a = int'($urandom_range(0, 255)) - 128;
         b = int'($urandom_range(0, 255)) - 128;
         run(a, b, 0);
         exp = model(a, b, 20);
         checks++;
         if (got20 !== exp) begin errs++; $display("FAIL rand20 it=%0d got=%h required=%h", it, got20, exp); end
         exp = model(a, b, 16);
         checks++;
         if (got16 !== exp) begin errs++; $display("FAIL rand16 it=%0d got=%h required=%h", it, got16, exp); end
         checks++;
         if (ndone != 1) begin errs++; $display("FAIL rand_done_count it=%0d got=%0d required=1", it, ndone); end
      end
   endtask

   task automatic test_busy_write();
      wcfg(0, 100); wcfg(1, -40); wcfg(6, 3);
      run(20, 10, 1);
      checks++;
      if (nerr != 1) begin errs++; $display("FAIL busy_cfg_err got=%0d required=1", nerr); end
      checks++;
      if (ndone != 1) begin errs++; $display("FAIL busy_done_count got=%0d required=1", ndone); end
      exp = model(20, 10, 20);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL busy_run20 got=%h required=%h", got20, exp); end
      run(20, 10, 0);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL busy_w1_kept got=%h required=%h", got20, exp); end
   endtask

   task automatic test_done_write();
      wcfg(1, 90);
      run(-7, 30, 3);
      checks++;
      if (nerr != 1) begin errs++; $display("FAIL done_cfg_err got=%0d required=1", nerr); end
      run(-7, 30, 0);
      exp = model(-7, 30, 20);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL done_w2_kept got=%h required=%h", got20, exp); end
   endtask

   task automatic test_bad_addr();
      wcfg(12, 8'h55);
      checks++;
      if ((cfg_err20 | cfg_err16) !== 1'b0) begin errs++; $display("FAIL bad_addr_err got=%b required=0", cfg_err20 | cfg_err16); end
      run(15, -15, 0);
      exp = model(15, -15, 20);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL bad_addr_run20 got=%h required=%h", got20, exp); end
      exp = model(15, -15, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL bad_addr_run16 got=%h required=%h", got16, exp); end
   endtask

   task automatic test_same_cycle();
      for (int i = 0; i < 6; i++) wcfg(i, 64);
      wcfg(6, -50); wcfg(7, 0); wcfg(8, 0);
      mb[0] = 10;
      run(5, 5, 4);
      exp = model(5, 5, 20);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL same_cycle20 got=%h required=%h", got20, exp); end
      exp = model(5, 5, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL same_cycle16 got=%h required=%h", got16, exp); end
   endtask

   task automatic test_reset_mid();
      run(5, 6, 2);
      checks++;
      if (rst_busy !== 1'b0) begin errs++; $display("FAIL rst_mid_busy got=%b required=0", rst_busy); end
      checks++;
      if (rst_or !== 8'd0) begin errs++; $display("FAIL rst_mid_outputs got=%h required=0", rst_or); end
      checks++;
      if (ndone != 0) begin errs++; $display("FAIL rst_mid_done_count got=%0d required=0", ndone); end
      for (int i = 0; i < 6; i++) mw[i] = 0;
      for (int i = 0; i < 3; i++) mb[i] = 0;
      for (int i = 0; i < 9; i++) wcfg(i, int'($urandom_range(0, 255)) - 128);
      run(7, -3, 0);
      exp = model(7, -3, 20);
      checks++;
      if (got20 !== exp) begin errs++; $display("FAIL rst_rerun20 got=%h required=%h", got20, exp); end
      exp = model(7, -3, 16);
      checks++;
      if (got16 !== exp) begin errs++; $display("FAIL rst_rerun16 got=%h required=%h", got16, exp); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_clip();
      test_random();
      test_busy_write();
      test_done_write();
      test_bad_addr();
      test_same_cycle();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
